// File: rtl/icache_pkg.sv
// Shared definitions for the N-way fetch-stage instruction cache:
// controller states and geometry helpers.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_REPLAY,
        S_FLUSH
    } state_e;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int set_num);
        return $clog2(set_num);
    endfunction

    function automatic int tag_w(input int addr_w, input int set_num, input int line_bytes);
        return addr_w - $clog2(set_num) - $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: tag and data SRAMs sharing an index, plus the tag compare.
module icache_way #(
    parameter  int SET_NUM   = 64,
    parameter  int TAG_W     = 52,
    parameter  int LINE_BITS = 512,
    localparam int IDX_W     = $clog2(SET_NUM)
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     addr,
    input  logic [TAG_W-1:0]     tag,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic                 line_valid,
    output logic                 hit,
    output logic [LINE_BITS-1:0] data
);

    logic [TAG_W-1:0] tag_q;
    logic             cen;

    assign cen = rd_en | wr_en;

    sram_model #(.DEPTH(SET_NUM), .WIDTH(TAG_W)) u_tag (
        .clk  (clk),
        .cen  (cen),
        .wen  (wr_en),
        .addr (addr),
        .d    (tag),
        .q    (tag_q)
    );

    sram_model #(.DEPTH(SET_NUM), .WIDTH(LINE_BITS)) u_data (
        .clk  (clk),
        .cen  (cen),
        .wen  (wr_en),
        .addr (addr),
        .d    (wr_data),
        .q    (data)
    );

    // The valid bit gates the compare, so never-written tag entries cannot hit.
    assign hit = line_valid && (tag_q == tag);

endmodule

// File: rtl/sram_model.sv
// Single-port synchronous SRAM: one-cycle read, Q holds while not enabled.
module sram_model #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             cen,
    input  logic             wen,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and Q are deliberately not reset; a macro has no reset,
    // and the valid flops in the controller decide whether contents matter.
    always_ff @(posedge clk) begin
        if (cen) begin
            if (wen) mem[addr] <= d;
            else     q         <= mem[addr];
        end
    end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only I-cache with round-robin replacement,
// single outstanding miss, squash-safe refill and whole-cache invalidate.
module icache_nway import icache_pkg::*; #(
    parameter  int ADDR_W     = 64,
    parameter  int WAY_NUM    = 4,
    parameter  int SET_NUM    = 64,
    parameter  int LINE_BYTES = 64,
    localparam int OFF_W      = off_w(LINE_BYTES),
    localparam int IDX_W      = idx_w(SET_NUM),
    localparam int WAY_W      = $clog2(WAY_NUM),
    localparam int TAG_W      = tag_w(ADDR_W, SET_NUM, LINE_BYTES),
    localparam int LINE_BITS  = 8 * LINE_BYTES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 f0_valid_i,
    output logic                 f0_ready_o,
    input  logic [ADDR_W-1:0]    f0_pc_i,
    output logic                 icache_valid_o,
    output logic [ADDR_W-1:0]    icache_pc_o,
    output logic [LINE_BITS-1:0] icache_data_o,
    input  logic                 stall_icache_i,
    output logic                 icache_miss_valid_o,
    input  logic                 icache_miss_ready_i,
    output logic [ADDR_W-1:0]    icache_miss_addr_o,
    input  logic                 refill_icache_valid_i,
    output logic                 refill_icache_ready_o,
    input  logic [LINE_BITS-1:0] refill_icache_data_i,
    input  logic                 squash_pipe_i,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic                 perf_hit_o,
    output logic                 perf_miss_o
);

    function automatic logic [IDX_W-1:0] pc_idx(input logic [ADDR_W-1:0] pc);
        return pc[OFF_W +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [ADDR_W-1:0] pc);
        return pc[ADDR_W-1 -: TAG_W];
    endfunction

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q;
    logic [WAY_W-1:0]     victim_q;
    logic                 drop_q;
    logic [WAY_NUM-1:0]   valid_q [SET_NUM];
    logic [WAY_W-1:0]     rr_q    [SET_NUM];

    logic [WAY_NUM-1:0]   way_hit;
    logic [LINE_BITS-1:0] way_data [WAY_NUM];
    logic [LINE_BITS-1:0] hit_data;
    logic [IDX_W-1:0]     cur_idx, sram_idx;
    logic [TAG_W-1:0]     cur_tag;
    logic                 hit, accept, sram_rd, miss_fire, refill_fire;

    assign cur_idx  = pc_idx(pc_q);
    assign cur_tag  = pc_tag(pc_q);
    assign hit      = (state_q == S_LOOKUP) && (|way_hit);

    assign f0_ready_o = !flush_i && !squash_pipe_i &&
                        ((state_q == S_IDLE) || (hit && !stall_icache_i));
    assign accept     = f0_valid_i && f0_ready_o;

    // A new accept and the replay read are the only SRAM reads; a stalled hit
    // issues none, so the SRAM outputs hold the line in place.
    assign sram_rd  = accept || (state_q == S_REPLAY);
    assign sram_idx = accept ? pc_idx(f0_pc_i) : cur_idx;

    assign icache_miss_valid_o   = (state_q == S_MISS_REQ);
    assign icache_miss_addr_o    = {pc_q[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign miss_fire             = icache_miss_valid_o && icache_miss_ready_i;
    assign refill_icache_ready_o = (state_q == S_MISS_WAIT);
    assign refill_fire           = refill_icache_valid_i && refill_icache_ready_o;

    assign icache_valid_o = hit && !squash_pipe_i;
    assign icache_pc_o    = pc_q;
    assign icache_data_o  = hit_data;
    assign perf_hit_o     = icache_valid_o && !stall_icache_i;
    assign perf_miss_o    = miss_fire;
    assign flush_done_o   = (state_q == S_FLUSH);

    for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
        icache_way #(.SET_NUM(SET_NUM), .TAG_W(TAG_W), .LINE_BITS(LINE_BITS)) u_way (
            .clk        (clk),
            .rd_en      (sram_rd),
            .wr_en      (refill_fire && (victim_q == WAY_W'(w))),
            .addr       (sram_idx),
            .tag        (cur_tag),
            .wr_data    (refill_icache_data_i),
            .line_valid (valid_q[cur_idx][w]),
            .hit        (way_hit[w]),
            .data       (way_data[w])
        );
    end

    always_comb begin
        hit_data = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (way_hit[w]) hit_data = hit_data | way_data[w];
        end
    end

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!squash_pipe_i) begin
                    if (flush_i)     state_d = S_FLUSH;
                    else if (accept) state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (squash_pipe_i)        state_d = S_IDLE;
                else if (|way_hit) begin
                    if (stall_icache_i)   state_d = S_LOOKUP;
                    else if (accept)      state_d = S_LOOKUP;
                    else if (flush_i)     state_d = S_FLUSH;
                    else                  state_d = S_IDLE;
                end
                else if (flush_i)         state_d = S_FLUSH;
                else                      state_d = S_MISS_REQ;
            end
            S_MISS_REQ: begin
                if (miss_fire)            state_d = S_MISS_WAIT;
                else if (squash_pipe_i)   state_d = S_IDLE;
            end
            S_MISS_WAIT: begin
                // The refill is always installed; only the replay is optional.
                if (refill_fire) begin
                    if (flush_i)                       state_d = S_FLUSH;
                    else if (drop_q || squash_pipe_i)  state_d = S_IDLE;
                    else                               state_d = S_REPLAY;
                end
            end
            S_REPLAY: begin
                if (flush_i)              state_d = S_FLUSH;
                else if (squash_pipe_i)   state_d = S_IDLE;
                else                      state_d = S_LOOKUP;
            end
            S_FLUSH:                      state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            victim_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept)    pc_q     <= f0_pc_i;
            if (miss_fire) victim_q <= rr_q[cur_idx];
            if (refill_fire)
                drop_q <= 1'b0;
            else if ((miss_fire || (state_q == S_MISS_WAIT)) && squash_pipe_i)
                drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SET_NUM; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (state_q == S_FLUSH) begin
            for (int s = 0; s < SET_NUM; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (refill_fire) begin
            valid_q[cur_idx][victim_q] <= 1'b1;
            rr_q[cur_idx]              <= rr_q[cur_idx] + WAY_W'(1);
        end
    end

    a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_LOOKUP) |-> $onehot0(way_hit));

endmodule
